// File: rtl/fmap_addr_gen_stream_if.sv
// Valid/ready stream carrying one IFM BRAM read address per beat, with an end-of-sweep marker.
interface fmap_addr_gen_stream_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output address, output valid, output last, input ready);
  modport slave  (input address, input valid, input last, output ready);
endinterface

// File: rtl/fmap_addr_gen_stream.sv
// IFM address generator: walks layer -> row window -> filter -> tap after a start pulse,
// emitting one read address per cycle on a valid/ready stream.
module fmap_addr_gen_stream #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned NUM_LAYERS    = 32,
  parameter int unsigned NUM_ROWS      = 20,
  parameter int unsigned NUM_FILTERS   = 64,
  parameter int unsigned KERNEL        = 3,
  parameter int unsigned ROW_STEP      = 3,
  parameter int unsigned FILTER_STRIDE = 16,
  parameter int unsigned LAYER_STRIDE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_ifm_bram_addr,
  fmap_addr_gen_stream_if.master out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ROWS_PER_LAYER = (NUM_ROWS - KERNEL) / ROW_STEP + 1;
  localparam int unsigned LW = (NUM_LAYERS     > 1) ? $clog2(NUM_LAYERS)     : 1;
  localparam int unsigned WW = (ROWS_PER_LAYER > 1) ? $clog2(ROWS_PER_LAYER) : 1;
  localparam int unsigned FW = (NUM_FILTERS    > 1) ? $clog2(NUM_FILTERS)    : 1;
  localparam int unsigned KW = (KERNEL         > 1) ? $clog2(KERNEL)         : 1;

  localparam logic [LW-1:0] L_MAX = LW'(NUM_LAYERS - 1);
  localparam logic [WW-1:0] W_MAX = WW'(ROWS_PER_LAYER - 1);
  localparam logic [FW-1:0] F_MAX = FW'(NUM_FILTERS - 1);
  localparam logic [KW-1:0] K_MAX = KW'(KERNEL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         l_q, l_d;
  logic [WW-1:0]         w_q, w_d;
  logic [FW-1:0]         f_q, f_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] layer_off_q, layer_off_d;
  logic [ADDR_WIDTH-1:0] filter_off_q, filter_off_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Running offsets replace the l/f/w multiplies; all arithmetic wraps at ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      l_q          <= '0;
      w_q          <= '0;
      f_q          <= '0;
      k_q          <= '0;
      base_q       <= '0;
      layer_off_q  <= '0;
      filter_off_q <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_q          <= l_d;
      w_q          <= w_d;
      f_q          <= f_d;
      k_q          <= k_d;
      base_q       <= base_d;
      layer_off_q  <= layer_off_d;
      filter_off_q <= filter_off_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state, counter carry chain (k -> f -> w -> l) and next registered outputs.
  always_comb begin
    state_d      = state_q;
    l_d          = l_q;
    w_d          = w_q;
    f_d          = f_q;
    k_d          = k_q;
    base_d       = base_q;
    layer_off_d  = layer_off_q;
    filter_off_d = filter_off_q;
    row_d        = row_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          base_d       = base_ifm_bram_addr;
          l_d          = '0;
          w_d          = '0;
          f_d          = '0;
          k_d          = '0;
          layer_off_d  = '0;
          filter_off_d = '0;
          row_d        = '0;
          valid_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      RUN: begin
        if (valid_q && out.ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (k_q != K_MAX) begin
            k_d = k_q + KW'(1);
          end else begin
            k_d = '0;
            if (f_q != F_MAX) begin
              f_d          = f_q + FW'(1);
              filter_off_d = filter_off_q + ADDR_WIDTH'(FILTER_STRIDE);
            end else begin
              f_d          = '0;
              filter_off_d = '0;
              if (w_q != W_MAX) begin
                w_d   = w_q + WW'(1);
                row_d = row_q + ADDR_WIDTH'(ROW_STEP);
              end else begin
                w_d         = '0;
                row_d       = '0;
                l_d         = l_q + LW'(1);
                layer_off_d = layer_off_q + ADDR_WIDTH'(LAYER_STRIDE);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Address and last marker always follow the next counter state, so holds are automatic.
    addr_d = base_d + layer_off_d + filter_off_d + row_d + ADDR_WIDTH'(k_d);
    last_d = valid_d && (l_d == L_MAX) && (w_d == W_MAX) && (f_d == F_MAX) && (k_d == K_MAX);
  end

  assign out.address = addr_q;
  assign out.valid   = valid_q;
  assign out.last    = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fmap_addr_gen_stream.sv
// Self-checking bench for fmap_addr_gen_stream: small, default and 8-bit wrap geometries.
module tb_fmap_addr_gen_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_start, s_busy, s_done;
  logic [31:0] s_base;
  logic        d_rst, d_start, d_busy, d_done;
  logic [31:0] d_base;
  logic        w_rst, w_start, w_busy, w_done;
  logic [7:0]  w_base;

  fmap_addr_gen_stream_if #(.ADDR_WIDTH(32)) s_if ();
  fmap_addr_gen_stream_if #(.ADDR_WIDTH(32)) d_if ();
  fmap_addr_gen_stream_if #(.ADDR_WIDTH(8))  w_if ();

  fmap_addr_gen_stream #(
    .ADDR_WIDTH(32), .NUM_LAYERS(2), .NUM_ROWS(5), .NUM_FILTERS(2), .KERNEL(3),
    .ROW_STEP(1), .FILTER_STRIDE(16), .LAYER_STRIDE(256)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .base_ifm_bram_addr(s_base),
    .out(s_if), .busy(s_busy), .done(s_done)
  );

  fmap_addr_gen_stream u_dflt (
    .clk(clk), .rst(d_rst), .start(d_start), .base_ifm_bram_addr(d_base),
    .out(d_if), .busy(d_busy), .done(d_done)
  );

  fmap_addr_gen_stream #(
    .ADDR_WIDTH(8), .NUM_LAYERS(1), .NUM_ROWS(3), .NUM_FILTERS(1), .KERNEL(3)
  ) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .base_ifm_bram_addr(w_base),
    .out(w_if), .busy(w_busy), .done(w_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] s_got[$], s_ref[$], d_got[$], w_got[$];
  logic        s_lst[$], s_ref_lst[$], d_lst[$], w_lst[$];

  typedef struct {
    int          sel;   // 0 small, 1 default, 2 wrap
    int          idx;
    logic [31:0] addr;
    logic        last;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One small-geometry sweep; leaves the bench at the negedge where done is high.
  task automatic small_sweep(input logic [31:0] base, input bit rnd, input bit poke);
    int          cyc;
    bit          hold_v;
    logic [31:0] hold_a;
    logic        hold_l;
    bit          prev_last_hs;
    cyc = 0; hold_v = 0; hold_a = '0; hold_l = 0; prev_last_hs = 0;
    s_got.delete();
    s_lst.delete();
    s_base  = base;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_first_valid", 32'(s_if.valid), 1);
    chk("s_first_busy", 32'(s_busy), 1);
    chk("s_first_addr", s_if.address, base);
    chk("s_done_pulse_len", 32'(s_done), 0);
    while (!s_done && cyc < 1000) begin
      if (hold_v) begin
        chk("s_hold_addr", s_if.address, hold_a);
        chk("s_hold_last", 32'(s_if.last), 32'(hold_l));
      end
      chk("s_valid_run", 32'(s_if.valid), 1);
      s_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        s_start = (s_got.size() == 5);
        if (s_got.size() >= 7) s_base = ~base;
      end
      hold_v = !s_if.ready;
      hold_a = s_if.address;
      hold_l = s_if.last;
      prev_last_hs = s_if.ready && s_if.last;
      if (s_if.valid && s_if.ready) begin
        s_got.push_back(s_if.address);
        s_lst.push_back(s_if.last);
      end
      @(negedge clk);
      cyc++;
    end
    s_start = 1'b0;
    if (!s_done) begin
      errors++;
      checks++;
      $display("FAIL s_timeout actual=%0d cycles without done required=done", cyc);
    end else begin
      chk("s_done_after_last", 32'(prev_last_hs), 1);
      chk("s_busy_in_done", 32'(s_busy), 0);
      chk("s_valid_in_done", 32'(s_if.valid), 0);
      chk("s_last_in_done", 32'(s_if.last), 0);
    end
  endtask

  // Compare the captured small sweep against the nested-loop address formula.
  task automatic check_small_seq(input logic [31:0] base, input string tag);
    int          i;
    logic [31:0] exp;
    i = 0;
    chk({tag, "_count"}, 32'(s_got.size()), 36);
    for (int l = 0; l < 2; l++)
      for (int w = 0; w < 3; w++)
        for (int f = 0; f < 2; f++)
          for (int k = 0; k < 3; k++) begin
            exp = base + 32'(l * 256) + 32'(f * 16) + 32'(w) + 32'(k);
            if (i < s_got.size()) begin
              chk($sformatf("%s_addr%0d", tag, i), s_got[i], exp);
              chk($sformatf("%s_last%0d", tag, i), 32'(s_lst[i]), 32'(i == 35));
            end
            i++;
          end
  endtask

  initial begin
    int          n;
    int          guard;
    int          nlast;
    logic [31:0] act_a;
    logic        act_l;
    int          qsz;

    vecs[0]  = '{0, 0,     32'h1000, 1'b0};
    vecs[1]  = '{0, 1,     32'h1001, 1'b0};
    vecs[2]  = '{0, 2,     32'h1002, 1'b0};
    vecs[3]  = '{0, 3,     32'h1010, 1'b0};
    vecs[4]  = '{0, 5,     32'h1012, 1'b0};
    vecs[5]  = '{0, 6,     32'h1001, 1'b0};
    vecs[6]  = '{0, 7,     32'h1002, 1'b0};
    vecs[7]  = '{0, 18,    32'h1100, 1'b0};
    vecs[8]  = '{0, 34,    32'h1113, 1'b0};
    vecs[9]  = '{0, 35,    32'h1114, 1'b1};
    vecs[10] = '{1, 0,     32'd0,    1'b0};
    vecs[11] = '{1, 3,     32'd16,   1'b0};
    vecs[12] = '{1, 192,   32'd3,    1'b0};
    vecs[13] = '{1, 36863, 32'd1025, 1'b1};
    vecs[14] = '{2, 0,     32'hFE,   1'b0};
    vecs[15] = '{2, 1,     32'hFF,   1'b0};
    vecs[16] = '{2, 2,     32'h00,   1'b1};

    s_rst = 0; d_rst = 0; w_rst = 0;
    s_start = 0; d_start = 0; w_start = 0;
    s_base = '0; d_base = '0; w_base = '0;
    s_if.ready = 0; d_if.ready = 0; w_if.ready = 0;

    #1;
    chk("rst_addr", s_if.address, 0);
    chk("rst_valid", 32'(s_if.valid), 0);
    chk("rst_last", 32'(s_if.last), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_d_valid", 32'(d_if.valid), 0);
    chk("rst_w_addr", 32'(w_if.address), 0);
    repeat (2) @(negedge clk);
    s_rst = 1; d_rst = 1; w_rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_no_start_valid", 32'(s_if.valid), 0);

    // Small geometry, full throughput
    small_sweep(32'h1000, 1'b0, 1'b0);
    check_small_seq(32'h1000, "s_plain");
    s_ref = s_got;
    s_ref_lst = s_lst;

    // Start accepted in the done cycle, new base
    small_sweep(32'h2000, 1'b0, 1'b0);
    check_small_seq(32'h2000, "s_b2b");
    repeat (2) @(negedge clk);

    // Backpressure
    small_sweep(32'h1000, 1'b1, 1'b0);
    check_small_seq(32'h1000, "s_bp");
    repeat (2) @(negedge clk);

    // Mid-sweep start pulse and base change are ignored
    small_sweep(32'h1000, 1'b0, 1'b1);
    check_small_seq(32'h1000, "s_poke");
    repeat (2) @(negedge clk);

    // Reset at handshake 10
    s_base = 32'h1000;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_if.ready = 1'b1;
    n = 0; guard = 0;
    while (n < 10 && guard < 100) begin
      if (s_if.valid) n++;
      @(negedge clk);
      guard++;
    end
    chk("s_pre_rst_addr", s_if.address, 32'h1000 + 32'h0100 - 32'h0100 + 32'h1 + 32'h10 + 32'h1);
    s_rst = 1'b0;
    #1;
    chk("s_rst_addr", s_if.address, 0);
    chk("s_rst_valid", 32'(s_if.valid), 0);
    chk("s_rst_last", 32'(s_if.last), 0);
    chk("s_rst_busy", 32'(s_busy), 0);
    chk("s_rst_done", 32'(s_done), 0);
    repeat (2) begin
      @(negedge clk);
      chk("s_rst_no_done", 32'(s_done), 0);
    end
    s_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s_post_rst_done", 32'(s_done), 0);
      chk("s_post_rst_idle", 32'(s_busy), 0);
    end
    small_sweep(32'h1000, 1'b0, 1'b0);
    check_small_seq(32'h1000, "s_after_rst");

    // Default geometry, base 0
    d_base = '0;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    d_if.ready = 1'b1;
    guard = 0; nlast = 0;
    while (!d_done && guard < 40000) begin
      if (d_if.valid) begin
        d_got.push_back(d_if.address);
        d_lst.push_back(d_if.last);
        if (d_if.last) nlast++;
      end
      @(negedge clk);
      guard++;
    end
    chk("d_done_seen", 32'(d_done), 1);
    chk("d_count", 32'(d_got.size()), 36864);
    chk("d_last_count", 32'(nlast), 1);
    chk("d_busy_in_done", 32'(d_busy), 0);

    // Wrap-around at 8 bits
    w_base = 8'hFE;
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    w_if.ready = 1'b1;
    guard = 0;
    while (!w_done && guard < 20) begin
      if (w_if.valid) begin
        w_got.push_back(32'(w_if.address));
        w_lst.push_back(w_if.last);
      end
      @(negedge clk);
      guard++;
    end
    chk("w_done_seen", 32'(w_done), 1);
    chk("w_count", 32'(w_got.size()), 3);

    // Table of hand-computed addresses
    for (int i = 0; i < 17; i++) begin
      act_a = '0;
      act_l = 1'b0;
      case (vecs[i].sel)
        0:       qsz = s_ref.size();
        1:       qsz = d_got.size();
        default: qsz = w_got.size();
      endcase
      if (vecs[i].idx >= qsz) begin
        checks++;
        errors++;
        $display("FAIL vec%0d_missing actual=%0d beats required>%0d", i, qsz, vecs[i].idx);
      end else begin
        case (vecs[i].sel)
          0:       begin act_a = s_ref[vecs[i].idx]; act_l = s_ref_lst[vecs[i].idx]; end
          1:       begin act_a = d_got[vecs[i].idx]; act_l = d_lst[vecs[i].idx]; end
          default: begin act_a = w_got[vecs[i].idx]; act_l = w_lst[vecs[i].idx]; end
        endcase
        chk($sformatf("vec%0d_addr", i), act_a, vecs[i].addr);
        chk($sformatf("vec%0d_last", i), 32'(act_l), 32'(vecs[i].last));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_addr_gen_stream.md
# fmap_addr_gen_stream

Parametrised input-feature-map address generator for the convolution layer. After a `start` pulse it walks layers, kernel-aligned row windows, output filters and kernel taps. It emits one IFM BRAM read address per cycle on a valid/ready stream, and reports completion with `out_last` and a `done` pulse. It replaces the fixed 32-layer/20-row/64-filter generator. It adds a configurable geometry, a layer stride, backpressure, one-address-per-cycle throughput and explicit completion signalling.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `NUM_LAYERS`, 32: input layers (≥1).
- `NUM_ROWS`, 20: rows per layer (≥`KERNEL`).
- `NUM_FILTERS`, 64: output filters (≥1).
- `KERNEL`, 3: taps per window (≥1).
- `ROW_STEP`, 3: row advance between windows (≥1).
- `FILTER_STRIDE`, 16: address offset per filter.
- `LAYER_STRIDE`, 0: address offset per layer. The default of 0 reproduces the legacy address map.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a full sweep; sampled only in IDLE.
- `base_ifm_bram_addr`  in  ADDR_WIDTH  base address; captured when `start` is accepted.
- `out_address`  out  ADDR_WIDTH  current read address.
- `out_valid`  out  1  `out_address` is valid.
- `out_ready`  in  1  consumer accepts the address this cycle.
- `out_last`  out  1  marks the final address of the sweep; qualified by `out_valid`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- Derived constants:
  - ROWS_PER_LAYER = floor((NUM_ROWS−KERNEL)/ROW_STEP)+1.
  - TOTAL = NUM_LAYERS·ROWS_PER_LAYER·NUM_FILTERS·KERNEL. Defaults give 6 windows and 36864 addresses.
- Iteration order, outer to inner:
  - layer l in 0..NUM_LAYERS−1
  - window w in 0..ROWS_PER_LAYER−1, with row r = w·ROW_STEP
  - filter f in 0..NUM_FILTERS−1
  - tap k in 0..KERNEL−1
- Address: base + l·LAYER_STRIDE + f·FILTER_STRIDE + r + k.
  - The sum is computed modulo 2^ADDR_WIDTH; wrap-around is silent.
  - The base is the latched copy captured at start.
  - Changing `base_ifm_bram_addr` mid-sweep has no effect.
- Counter widths are $clog2 of each bound, minimum 1 bit.
- Address formation may use running offset registers instead of multipliers; only the emitted sequence is specified.
- States: IDLE and RUN.
  - IDLE, `start`=1: latch base, clear counters, load the address for (0,0,0,0), set `out_valid`=1 and `busy`=1, go to RUN. Set `out_last`=1 immediately if TOTAL=1.
  - IDLE, `start`=0: hold.
  - RUN, `out_valid`&`out_ready`, not last: advance the innermost counter with carry (k→f→w→l) and load the next address. `out_valid` stays 1 with no bubble.
  - RUN, `out_valid`&`out_ready`, last: clear `out_valid` and `out_last`, clear `busy`, pulse `done`=1, go to IDLE.
  - RUN, `out_ready`=0: `out_address`, `out_last` and the counters hold unchanged.
- `start` during RUN is ignored; it is neither queued nor able to restart the sweep.
- `out_last` is high exactly when the counters equal (NUM_LAYERS−1, ROWS_PER_LAYER−1, NUM_FILTERS−1, KERNEL−1).

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, all counters 0, and every output 0 (`out_address`, `out_valid`, `out_last`, `busy`, `done`).
  - Reset mid-sweep aborts immediately; no `done` pulse is issued.
  - After `rst` deasserts, the block waits for a new `start`.
- Latency: with `start` sampled at edge N, the first address is valid after edge N (cycle N+1).
- Throughput: one address per cycle while `out_ready`=1. A full default sweep with `out_ready` held high takes 36864 RUN cycles.
- `done` is high for exactly one cycle, the cycle after the last handshake. `busy` is 0 in that same cycle.
- A new `start` is accepted on the same edge where `done` is high, because the state is already IDLE. The first address of the new sweep is then valid one cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Small geometry: NUM_LAYERS=2, NUM_ROWS=5, NUM_FILTERS=2, KERNEL=3, ROW_STEP=1, FILTER_STRIDE=16, LAYER_STRIDE=256, base 0x1000, `out_ready`=1.
  - Required sequence starts 0x1000, 0x1001, 0x1002, 0x1010, 0x1011, 0x1012, 0x1001, 0x1002, …
  - Exactly 36 addresses; the last is 0x1114, with `out_last` on it only.
  - `done` pulses 1 cycle later.
- Default parameters, base 0:
  - 36864 handshakes.
  - Address index 3 is 16 (filter 1, tap 0).
  - Index 192 is 3 (window 1, filter 0, tap 0).
  - The final address is 63·16+15+2 = 1025.
- Backpressure: use the small geometry with a random `out_ready` (≈50%).
  - The accepted sequence is identical to the first scenario.
  - `out_address` and `out_last` are stable on every cycle where `out_valid`=1 and `out_ready`=0.
- Wrap-around: ADDR_WIDTH=8, base 0xFE, KERNEL=3, NUM_LAYERS=NUM_FILTERS=1, NUM_ROWS=3.
  - Required addresses: 0xFE, 0xFF, 0x00.
  - `out_last` is high on 0x00.
- Control corner cases:
  - `start` pulsed mid-sweep → ignored; the sweep count is unchanged.
  - `start` in the `done` cycle → second sweep begins with its first address valid 1 cycle later.
  - `base_ifm_bram_addr` changed mid-sweep → no effect on emitted addresses.
- Reset mid-sweep: drive `rst` low at handshake 10.
  - All outputs are 0 in the same cycle (asynchronous).
  - No `done` pulse.
  - After release and a fresh `start`, the sequence restarts at the base address.
